// File: rtl/aes_pkg.sv
// AES S-box constants, byte type and engine state encoding shared by the SubBytes engine.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package aes_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_lane.sv
// One S-box lane: substitutes a single byte through the forward or inverse table.
// Latency: purely combinational.
// Backpressure: none; the engine sequences the lanes.
// Ports: byte_i (byte to substitute), inv_i (1 = inverse table), byte_o (substituted byte).
module sbox_lane
  import aes_pkg::*;
(
  input  byte_t byte_i,
  input  logic  inv_i,
  output byte_t byte_o
);

  assign byte_o = inv_i ? INV_SBOX[byte_i] : SBOX[byte_i];

endmodule

// File: rtl/sub_bytes_engine.sv
// AES SubBytes engine: substitutes an NBYTES-byte word, LANES bytes per clock, forward or inverse per word.
// Latency: out_valid rises NBYTES/LANES cycles after the acceptance edge.
// Backpressure: the result is held in DONE until out_ready; in_ready follows out_ready in DONE so words stream back to back.
// Ports: clk/rst (async active-high); in_valid/in_ready/in_data/in_inv input handshake with per-word mode;
//        out_valid/out_ready/out_data result handshake; busy high while substituting.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int NBYTES = 16,
  parameter int LANES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_data,
  input  logic                  in_inv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_data,
  output logic                  busy
);

  localparam int GROUPS = NBYTES / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                inv_q, inv_d;
  logic [8*NBYTES-1:0] work_q, work_d;

  byte_t lane_in  [LANES];
  byte_t lane_out [LANES];

  // Lane k sees byte cnt*LANES+k: a GROUPS-way mux per lane.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_in[k] = '0;
    end
    for (int g = 0; g < GROUPS; g++) begin
      if (cnt_q == CW'(g)) begin
        for (int k = 0; k < LANES; k++) begin
          lane_in[k] = work_q[(g*LANES+k)*8 +: 8];
        end
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sbox_lane u_lane (
      .byte_i (lane_in[k]),
      .inv_i  (inv_q),
      .byte_o (lane_out[k])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    inv_d    = inv_q;
    work_d   = work_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_data;
          inv_d   = in_inv;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int g = 0; g < GROUPS; g++) begin
          if (cnt_q == CW'(g)) begin
            for (int k = 0; k < LANES; k++) begin
              work_d[(g*LANES+k)*8 +: 8] = lane_out[k];
            end
          end
        end
        // Counter stops on the last group; the next acceptance clears it.
        if (cnt_q == CW'(GROUPS-1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        // Result leaves and a new word may enter on the same edge.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            work_d  = in_data;
            inv_d   = in_inv;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      work_q  <= work_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_data  = work_q;

endmodule

// File: doc/sub_bytes_engine.md
Name: sub_bytes_engine

Overview:
Parametrised AES SubBytes engine that substitutes an NBYTES-byte word through forward or inverse S-box lanes.
- Processes LANES bytes per clock, so one word takes NBYTES/LANES cycles, trading area against throughput.
- Mode (forward/inverse) is selected per word.
- Sits between the round-state register and ShiftRows/InvShiftRows, with valid/ready handshakes on both sides.

Parameters:
- NBYTES, 16, bytes per word (state width = 8*NBYTES); must be a multiple of LANES.
- LANES, 4, S-box lanes instantiated; bytes substituted per cycle; 1 <= LANES <= NBYTES.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  engine can accept a word this cycle.
- in_data  in  8*NBYTES  input word; byte j = in_data[8j+7:8j].
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box; sampled with the word.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  8*NBYTES  substituted word, same byte order as in_data.
- busy  out  1  high while a word is being substituted (BUSY state).

Behaviour:
- Reset (async, any time, including mid-word):
  - state = IDLE; out_valid = 0; out_data = 0; busy = 0; group counter = 0; latched mode = 0.
  - Any partial word is discarded and no output is produced for it.
- States:
  - IDLE: in_ready = 1.
    - On in_valid & in_ready: load the working register from in_data, latch in_inv, set counter = 0, go to BUSY.
  - BUSY: in_ready = 0, busy = 1.
    - Each edge replaces bytes counter*LANES .. counter*LANES+LANES-1 with S(byte) or S^-1(byte) per the latched mode, then increments the counter.
    - On the edge processing the last group (counter = NBYTES/LANES-1), go to DONE with out_valid = 1.
  - DONE: out_valid = 1; out_data = working register, held stable until the transfer.
    - in_ready = out_ready (combinational).
    - out_ready = 1 and in_valid = 0: the result transfers; go to IDLE, out_valid = 0.
    - out_ready = 1 and in_valid = 1: the result transfers and the new word is loaded in the same edge; go to BUSY. Back-to-back words have no bubble on the input side.
    - out_ready = 0: hold everything; in_valid is ignored.
- Latency: out_valid rises NBYTES/LANES cycles after the acceptance edge.
  - Defaults: 4 cycles.
  - LANES = NBYTES: 1 cycle; BUSY lasts one edge.
- Throughput: one word per NBYTES/LANES + 1 cycles with out_ready held at 1 and in_valid held at 1 (DONE overlaps the next acceptance).
- Counter width: clog2(NBYTES/LANES), minimum 1 bit.
  - The counter never wraps inside a word; it resets to 0 on every acceptance.
- in_data and in_inv are don't-care except at the acceptance edge. Changing in_inv during BUSY has no effect.
- out_data is not cleared on leaving DONE; it reflects the working register. Consumers qualify it with out_valid only.
- S-box values follow the FIPS-197 tables. Inverse entries are exact inverses, so S^-1(S(x)) = x for all 256 x.

Decomposition:
- Shared package aes_pkg:
  - 256-entry SBOX and INV_SBOX byte constant arrays.
  - byte typedef.
  - state enum {IDLE, BUSY, DONE}.
- One sub-module, sbox_lane: combinational, ports byte in, inv, byte out; selects SBOX or INV_SBOX from aes_pkg.
  - The engine instantiates LANES copies.
  - Lane k reads byte counter*LANES+k through an NBYTES/LANES-way mux and writes it back.

Test Plan:
- Reset/idle: assert rst mid-BUSY (defaults) → within the same cycle out_valid = 0, busy = 0, out_data = 0; after release in_ready = 1; the aborted word never appears.
- Forward, all-zero word: in_data = 0, in_inv = 0 → out_valid exactly 4 cycles after acceptance; out_data = {16{8'h63}}; busy high for exactly 4 cycles.
- Inverse known values: byte 0 = 8'h63, byte 1 = 8'hED, byte 2 = 8'h16, rest 8'h52, in_inv = 1 → bytes 8'h00, 8'h53, 8'hFF, rest 8'h48.
- Round trip, exhaustive: all 256 byte values packed across 16 words, forward then feed output back with in_inv = 1 → original words, with LANES = 1, 4 and 16 (latency 16, 4, 1).
- Backpressure: hold out_ready = 0 for 10 cycles in DONE with in_valid = 1 → out_data stable, in_ready = 0, no new word accepted; then out_ready = 1 → transfer and new acceptance on the same edge.
- Back-to-back streaming: in_valid and out_ready held at 1 for 8 words with alternating in_inv → one result every 5 cycles (defaults), each matching the model for its own latched mode.
